// File: rtl/regfile_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter_if
// Brief    : Pipeline, host and regfile-side signals of the regfile arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_arbiter_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  cpu_wr_en;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic [BUS_WIDTH-1:0]  cpu_wr_data;
  logic [ADDR_WIDTH-1:0] cpu_rd2_addr;
  logic                  cpu_stall;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [BUS_WIDTH-1:0]  host_wdata;
  logic                  host_ack;
  logic [BUS_WIDTH-1:0]  host_rdata;

  logic                  rf_write;
  logic [ADDR_WIDTH-1:0] rf_writeReg;
  logic [BUS_WIDTH-1:0]  rf_writeData;
  logic [ADDR_WIDTH-1:0] rf_readReg2;
  logic [BUS_WIDTH-1:0]  rf_readData2;

  // Arbiter side
  modport slave (
    input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd2_addr,
    input  host_req, host_we, host_addr, host_wdata,
    input  rf_readData2,
    output cpu_stall, host_ack, host_rdata,
    output rf_write, rf_writeReg, rf_writeData, rf_readReg2
  );

  // Environment side: pipeline, host and regfile
  modport master (
    output cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd2_addr,
    output host_req, host_we, host_addr, host_wdata,
    output rf_readData2,
    input  cpu_stall, host_ack, host_rdata,
    input  rf_write, rf_writeReg, rf_writeData, rf_readReg2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Brief    : Shares the regfile write port and read port 2 between the
//            pipeline (priority) and a host, with a starvation guard.
//            Optional macro REGFILE_ARB_HOST_READ_EN enables host reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
  parameter int BUS_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CAP = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_starve_cnt;
  logic                 w_grant;
  logic [BUS_WIDTH-1:0] r_host_rdata;

  assign w_grant = (r_state == IDLE) && bus.host_req &&
                   (!bus.cpu_wr_en || (r_starve_cnt == c_starve_limit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
`ifdef REGFILE_ARB_HOST_READ_EN
          w_next_state = bus.host_we ? ACK : RD_CAP;
`else
          w_next_state = ACK;
`endif
        end
      end
      RD_CAP:  w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Counts host cycles lost to pipeline writes; only meaningful while waiting in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == IDLE) begin
      if (!bus.host_req) begin
        r_starve_cnt <= 4'd0;
      end else if (bus.cpu_wr_en && (r_starve_cnt != c_starve_limit)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    bus.rf_write     = bus.cpu_wr_en;
    bus.rf_writeReg  = bus.cpu_wr_addr;
    bus.rf_writeData = bus.cpu_wr_data;
    bus.rf_readReg2  = bus.cpu_rd2_addr;
    if (w_grant) begin
      bus.rf_write     = bus.host_we;
      bus.rf_writeReg  = bus.host_addr;
      bus.rf_writeData = bus.host_wdata;
`ifdef REGFILE_ARB_HOST_READ_EN
      bus.rf_readReg2  = bus.host_addr;
`endif
    end else if (r_state == RD_CAP) begin
      // The pipeline is still stalled here, so its pending write must not land
      bus.rf_write     = 1'b0;
      bus.rf_readReg2  = bus.host_addr;
    end
  end

`ifdef REGFILE_ARB_HOST_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_rdata <= '0;
    end else if (r_state == RD_CAP) begin
      r_host_rdata <= bus.rf_readData2;
    end
  end
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.rf_readData2;
  assign r_host_rdata   = '0;
`endif

  assign bus.cpu_stall  = w_grant || (r_state == RD_CAP);
  assign bus.host_ack   = (r_state == ACK);
  assign bus.host_rdata = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Brief    : Directed bench for regfile_arbiter with a behavioural regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_HOST_READ_EN
  localparam bit c_rd_en = 1'b1;
`else
  localparam bit c_rd_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   x7_cnt = 0;

  logic [31:0] regs [32];
  logic [31:0] rd2_q;

  regfile_arbiter_if #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) bif ();

  regfile_arbiter #(
    .BUS_WIDTH   (32),
    .ADDR_WIDTH  (5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  always #5 clk = ~clk;

  // Regfile: registered read port 2 with write-through, x0 hard-wired to zero
  always @(posedge clk) begin
    if (bif.rf_write && (bif.rf_writeReg != 5'd0))
      regs[bif.rf_writeReg] <= bif.rf_writeData;
    if (bif.rf_write && (bif.rf_writeReg != 5'd0) && (bif.rf_writeReg == bif.rf_readReg2))
      rd2_q <= bif.rf_writeData;
    else
      rd2_q <= regs[bif.rf_readReg2];
    if (bif.rf_write && (bif.rf_writeReg == 5'd7))
      x7_cnt <= x7_cnt + 1;
  end
  assign bif.rf_readData2 = rd2_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One host transaction with the pipeline idle
  task automatic host_txn(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd);
    bif.host_req   = 1'b1;
    bif.host_we    = we;
    bif.host_addr  = a;
    bif.host_wdata = d;
    #1;
    chk("grant_stall", 32'(bif.cpu_stall), 32'd1);
    chk("grant_rf_write", 32'(bif.rf_write), 32'(we));
    chk("grant_ack", 32'(bif.host_ack), 32'd0);
    if (we) begin
      chk("grant_wreg", 32'(bif.rf_writeReg), 32'(a));
      chk("grant_wdata", bif.rf_writeData, d);
    end else if (c_rd_en) begin
      chk("grant_rd2", 32'(bif.rf_readReg2), 32'(a));
    end else begin
      chk("grant_rd2_cpu", 32'(bif.rf_readReg2), 32'(bif.cpu_rd2_addr));
    end
    tick();
    if (!we && c_rd_en) begin
      chk("rdcap_stall", 32'(bif.cpu_stall), 32'd1);
      chk("rdcap_ack", 32'(bif.host_ack), 32'd0);
      chk("rdcap_rf_write", 32'(bif.rf_write), 32'd0);
      tick();
    end
    chk("ack_pulse", 32'(bif.host_ack), 32'd1);
    chk("ack_stall", 32'(bif.cpu_stall), 32'd0);
    if (!we) chk("ack_rdata", bif.host_rdata, exp_rd);
    bif.host_req = 1'b0;
    tick();
    chk("ack_gone", 32'(bif.host_ack), 32'd0);
    if (!we) chk("rdata_hold", bif.host_rdata, exp_rd);
  endtask

  // Pipeline writes every cycle; host must wait exactly 4 denied cycles
  task automatic starve_round(input logic [4:0] ha, input logic [31:0] hd,
                              input logic [4:0] sa, input logic [31:0] sd);
    bif.host_req   = 1'b1;
    bif.host_we    = 1'b1;
    bif.host_addr  = ha;
    bif.host_wdata = hd;
    bif.cpu_wr_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.cpu_wr_addr = 5'(10 + i);
      bif.cpu_wr_data = 32'h100 + 32'(i);
      #1;
      chk("starve_nostall", 32'(bif.cpu_stall), 32'd0);
      chk("starve_cpu_wreg", 32'(bif.rf_writeReg), 32'(10 + i));
      chk("starve_cpu_wr", 32'(bif.rf_write), 32'd1);
      tick();
    end
    bif.cpu_wr_addr = sa;
    bif.cpu_wr_data = sd;
    #1;
    chk("forced_stall", 32'(bif.cpu_stall), 32'd1);
    chk("forced_wreg", 32'(bif.rf_writeReg), 32'(ha));
    chk("forced_wdata", bif.rf_writeData, hd);
    tick();
    chk("forced_ack", 32'(bif.host_ack), 32'd1);
    chk("replay_stall", 32'(bif.cpu_stall), 32'd0);
    chk("replay_wreg", 32'(bif.rf_writeReg), 32'(sa));
    chk("replay_wdata", bif.rf_writeData, sd);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rd2_q            = 32'd0;
    bif.cpu_wr_en    = 1'b0;
    bif.cpu_wr_addr  = 5'd0;
    bif.cpu_wr_data  = 32'd0;
    bif.cpu_rd2_addr = 5'd9;
    bif.host_req     = 1'b0;
    bif.host_we      = 1'b0;
    bif.host_addr    = 5'd0;
    bif.host_wdata   = 32'd0;
    tick();
    tick();
    chk("rst_stall", 32'(bif.cpu_stall), 32'd0);
    chk("rst_ack", 32'(bif.host_ack), 32'd0);
    chk("rst_rdata", bif.host_rdata, 32'd0);
    chk("rst_rf_write", 32'(bif.rf_write), 32'd0);
    rst = 1'b0;
    tick();

    host_txn(1'b1, 5'd5, 32'hDEADBEEF, 32'd0);
    chk("x5_model", regs[5], 32'hDEADBEEF);
    host_txn(1'b0, 5'd5, 32'd0, c_rd_en ? 32'hDEADBEEF : 32'd0);

    host_txn(1'b1, 5'd0, 32'h00001234, 32'd0);
    host_txn(1'b0, 5'd0, 32'd0, 32'd0);
    host_txn(1'b0, 5'd5, 32'd0, c_rd_en ? 32'hDEADBEEF : 32'd0);

    // host_req stays high across rounds so a stale counter would grant at once
    starve_round(5'd20, 32'h0000A5A5, 5'd7, 32'h77770007);
    starve_round(5'd21, 32'h00005A5A, 5'd8, 32'h88880008);
    bif.host_req  = 1'b0;
    bif.cpu_wr_en = 1'b0;
    tick();
    chk("x7_value", regs[7], 32'h77770007);
    chk("x7_once", 32'(x7_cnt), 32'd1);
    chk("x8_value", regs[8], 32'h88880008);
    chk("x20_value", regs[20], 32'h0000A5A5);
    chk("x21_value", regs[21], 32'h00005A5A);
    chk("x13_value", regs[13], 32'h00000103);

    // Reset one cycle after a read grant: RD_CAP, or ACK without host reads
    bif.host_req  = 1'b1;
    bif.host_we   = 1'b0;
    bif.host_addr = 5'd3;
    #1;
    chk("abort_grant", 32'(bif.cpu_stall), 32'd1);
    tick();
    rst          = 1'b1;
    bif.host_req = 1'b0;
    #1;
    chk("abort_ack", 32'(bif.host_ack), 32'd0);
    chk("abort_stall", 32'(bif.cpu_stall), 32'd0);
    chk("abort_rdata", bif.host_rdata, 32'd0);
    tick();
    chk("abort_ack_rst", 32'(bif.host_ack), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_ack_after", 32'(bif.host_ack), 32'd0);
    chk("abort_stall_after", 32'(bif.cpu_stall), 32'd0);

    host_txn(1'b0, 5'd3, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
